// File: rtl/multdiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, op type, watchdog default.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  localparam int TIMEOUT_CYC_DEFAULT = 40;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Pipeline request/response and mult/div unit signals of multdiv_ctrl, bundled in one interface.
interface multdiv_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             req_mult;
  logic             req_div;
  logic [31:0]      req_opA;
  logic [31:0]      req_opB;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             busy;
  logic             rsp_valid;
  logic [31:0]      rsp_result;
  logic             rsp_exception;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      md_operandA;
  logic [31:0]      md_operandB;
  logic             md_ctrl_MULT;
  logic             md_ctrl_DIV;
  logic [31:0]      md_result;
  logic             md_exception;
  logic             md_resultRDY;

  // Controller side
  modport slave (
    input  req_mult, req_div, req_opA, req_opB, req_tag, flush,
    input  md_result, md_exception, md_resultRDY,
    output busy, rsp_valid, rsp_result, rsp_exception, rsp_tag,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV
  );

  // Pipeline plus unit side
  modport master (
    output req_mult, req_div, req_opA, req_opB, req_tag, flush,
    output md_result, md_exception, md_resultRDY,
    input  busy, rsp_valid, rsp_result, rsp_exception, rsp_tag,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV
  );
endinterface

// File: rtl/md_watchdog.sv
// WAIT-cycle watchdog for multdiv_ctrl; only instantiated when MULTDIV_TIMEOUT_EN is defined.
module md_watchdog
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run_i,
  output logic expired_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count holds the number of WAIT cycles already completed, so it reads
  // TIMEOUT_CYC-1 during the last allowed WAIT cycle.
  assign cnt_d     = run_i ? cnt_q + CNT_W'(1) : '0;
  assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and a multi-cycle mult/div unit: IDLE -> ISSUE -> WAIT -> DONE.
// Optional WAIT watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  multdiv_ctrl_if.slave bus
);
  md_state_e        state_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic             rsp_exc_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic [TAG_W-1:0] tag_q;
  logic             ctrl_mult_q;
  logic             ctrl_div_q;

  logic             accept_d;
  md_op_e           op_d;
  logic             timeout_d;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("multdiv_ctrl: TIMEOUT_CYC must be at least 1");
  end

  assign accept_d = (bus.req_mult | bus.req_div) & ~bus.flush &
                    ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign op_d     = bus.req_mult ? OP_MULT : OP_DIV;

`ifdef MULTDIV_TIMEOUT_EN
  md_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .run_i     (state_q == ST_WAIT),
    .expired_o (timeout_d)
  );
`else
  assign timeout_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_exc_q    <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      tag_q        <= '0;
      ctrl_mult_q  <= 1'b0;
      ctrl_div_q   <= 1'b0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_d) begin
            state_q     <= ST_ISSUE;
            busy_q      <= 1'b1;
            opa_q       <= bus.req_opA;
            opb_q       <= bus.req_opB;
            tag_q       <= bus.req_tag;
            ctrl_mult_q <= (op_d == OP_MULT);
            ctrl_div_q  <= (op_d == OP_DIV);
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        // md_resultRDY is deliberately not looked at here: the unit still shows the previous op.
        ST_ISSUE: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.md_resultRDY) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_exc_q    <= bus.md_exception;
            rsp_result_q <= bus.md_exception ? 32'd0 : bus.md_result;
            rsp_tag_q    <= tag_q;
          end else if (timeout_d) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_exc_q    <= 1'b1;
            rsp_result_q <= 32'd0;
            rsp_tag_q    <= tag_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_exception = rsp_exc_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.md_operandA   = opa_q;
  assign bus.md_operandB   = opb_q;
  assign bus.md_ctrl_MULT  = ctrl_mult_q;
  assign bus.md_ctrl_DIV   = ctrl_div_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: vector table plus hand sequences; a stub models the mult/div unit.
module tb_multdiv_ctrl;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  multdiv_ctrl_if #(.TAG_W(5)) bus ();

  multdiv_ctrl #(
    .TAG_W       (5),
    .TIMEOUT_CYC (40)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stub unit: shows a stale ready with junk during ISSUE, then real result after stub_lat cycles.
  // stub_lat == 0 means the unit never answers.
  int          stub_lat = 1;
  int          stub_cnt = 0;
  logic [31:0] stub_res;
  logic        stub_exc;
  always @(negedge clock) begin
    logic signed [31:0] sa, sb;
    sa = bus.md_operandA;
    sb = bus.md_operandB;
    if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
      if (bus.md_ctrl_MULT) begin
        stub_res = sa * sb;
        stub_exc = 1'b0;
      end else if (sb == 0) begin
        stub_res = 32'hDEADBEEF;
        stub_exc = 1'b1;
      end else begin
        stub_res = sa / sb;
        stub_exc = 1'b0;
      end
      stub_cnt         = stub_lat;
      bus.md_resultRDY = 1'b1;
      bus.md_result    = 32'hBADBAD00;
      bus.md_exception = 1'b1;
    end else if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      bus.md_resultRDY = (stub_cnt == 0);
      bus.md_result    = stub_res;
      bus.md_exception = stub_exc;
    end else begin
      bus.md_resultRDY = 1'b0;
      bus.md_result    = 32'h0;
      bus.md_exception = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    bus.req_mult = 1'b0;
    bus.req_div  = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive_req(input bit m, input bit d, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
    bus.req_mult = m;
    bus.req_div  = d;
    bus.req_opA  = a;
    bus.req_opB  = b;
    bus.req_tag  = tag;
  endtask

  // One operation, observed at each negedge; cycle k=1 is the ISSUE cycle.
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int lat, input int flush_at,
                        input int inject_at, input int maxc,
                        output int n_valid, output int valid_cyc, output int mult_p,
                        output int div_p, output logic [31:0] res, output logic exc,
                        output logic [4:0] rtag, output bit stable, output logic busy_post);
    stub_lat = lat;
    n_valid = 0; valid_cyc = 0; mult_p = 0; div_p = 0;
    res = '0; exc = 1'b0; rtag = '0; stable = 1'b1; busy_post = 1'b0;
    @(negedge clock);
    drive_req(m, d, a, b, tag);
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clock);
      clear_req();
      if (bus.md_ctrl_MULT) mult_p++;
      if (bus.md_ctrl_DIV) div_p++;
      if ((bus.busy || bus.rsp_valid) && (bus.md_operandA !== a || bus.md_operandB !== b))
        stable = 1'b0;
      if (bus.rsp_valid) begin
        n_valid++;
        if (n_valid == 1) begin
          valid_cyc = k;
          res  = bus.rsp_result;
          exc  = bus.rsp_exception;
          rtag = bus.rsp_tag;
        end
      end
      if (k == flush_at + 1) busy_post = bus.busy;
      if (k == flush_at) bus.flush = 1'b1;
      if (k == inject_at) drive_req(1'b1, 1'b1, 32'h99, 32'h77, 5'd7);
    end
  endtask

  task automatic wait_valid(input int maxc, output bit found);
    found = 1'b0;
    for (int k = 0; k < maxc && !found; k++) begin
      @(negedge clock);
      if (bus.rsp_valid) found = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag_s);
    check({tag_s, "_busy"},  bus.busy, 0);
    check({tag_s, "_valid"}, bus.rsp_valid, 0);
    check({tag_s, "_res"},   bus.rsp_result, 0);
    check({tag_s, "_exc"},   bus.rsp_exception, 0);
    check({tag_s, "_tag"},   bus.rsp_tag, 0);
    check({tag_s, "_opA"},   bus.md_operandA, 0);
    check({tag_s, "_opB"},   bus.md_operandB, 0);
    check({tag_s, "_mul"},   bus.md_ctrl_MULT, 0);
    check({tag_s, "_div"},   bus.md_ctrl_DIV, 0);
  endtask

  typedef struct {
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          lat;
    logic [31:0] exp_res;
    bit          exp_exc;
    bit          exp_mult;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n_valid, valid_cyc, mult_p, div_p;
    logic [31:0] res;
    logic exc, busy_post;
    logic [4:0] rtag;
    bit stable, found;
    int cnt;

    vecs[0] = '{1, 0, 32'd7,        32'hFFFFFFFA, 5'd3,  3, 32'hFFFFFFD6, 0, 1};
    vecs[1] = '{0, 1, 32'd100,      32'hFFFFFFF9, 5'd9,  5, 32'hFFFFFFF2, 0, 0};
    vecs[2] = '{0, 1, 32'd5,        32'd0,        5'd1,  2, 32'h00000000, 1, 0};
    vecs[3] = '{1, 1, 32'hFFFFFFFD, 32'hFFFFFFFC, 5'd31, 1, 32'd12,       0, 1};
    vecs[4] = '{1, 0, 32'h00010000, 32'h00010000, 5'd17, 4, 32'h00000000, 0, 1};
    vecs[5] = '{0, 1, 32'h80000000, 32'd3,        5'd0,  6, 32'hD5555556, 0, 0};

    reset_n = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.flush = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].lat, 0, 0,
             vecs[i].lat + 5, n_valid, valid_cyc, mult_p, div_p, res, exc, rtag, stable, busy_post);
      $display("vec %0d: a=0x%08h b=0x%08h -> res=0x%08h exc=%0d tag=%0d at cycle %0d",
               i, vecs[i].a, vecs[i].b, res, exc, rtag, valid_cyc);
      check($sformatf("v%0d_nvalid", i), n_valid, 1);
      check($sformatf("v%0d_latency", i), valid_cyc, vecs[i].lat + 2);
      check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("v%0d_exc", i), exc, vecs[i].exp_exc);
      check($sformatf("v%0d_tag", i), rtag, vecs[i].tag);
      check($sformatf("v%0d_mulpulse", i), mult_p, vecs[i].exp_mult ? 1 : 0);
      check($sformatf("v%0d_divpulse", i), div_p, vecs[i].exp_mult ? 0 : 1);
      check($sformatf("v%0d_opstable", i), stable, 1);
    end

    // Request arriving while busy must be ignored
    run_op(1, 0, 32'd2, 32'd5, 5'd4, 6, 0, 3, 12,
           n_valid, valid_cyc, mult_p, div_p, res, exc, rtag, stable, busy_post);
    $display("busy-ignore: res=0x%08h tag=%0d mul=%0d div=%0d", res, rtag, mult_p, div_p);
    check("bsy_mulpulse", mult_p, 1);
    check("bsy_divpulse", div_p, 0);
    check("bsy_nvalid", n_valid, 1);
    check("bsy_result", res, 32'd10);
    check("bsy_tag", rtag, 5'd4);
    check("bsy_opstable", stable, 1);

    // Flush on the 5th WAIT cycle, then a fresh 2*3
    run_op(1, 0, 32'd9, 32'd9, 5'd2, 10, 6, 0, 20,
           n_valid, valid_cyc, mult_p, div_p, res, exc, rtag, stable, busy_post);
    $display("flush: nvalid=%0d busy_after=%0d", n_valid, busy_post);
    check("fl_nvalid", n_valid, 0);
    check("fl_busy_after", busy_post, 0);
    run_op(1, 0, 32'd2, 32'd3, 5'd5, 2, 0, 0, 8,
           n_valid, valid_cyc, mult_p, div_p, res, exc, rtag, stable, busy_post);
    $display("after flush: res=0x%08h tag=%0d", res, rtag);
    check("fl_next_nvalid", n_valid, 1);
    check("fl_next_result", res, 32'd6);
    check("fl_next_tag", rtag, 5'd5);

    // Back-to-back: request accepted in DONE; response fields hold meanwhile
    stub_lat = 1;
    @(negedge clock);
    drive_req(1'b1, 1'b0, 32'd4, 32'd5, 5'd6);
    @(negedge clock);
    clear_req();
    wait_valid(10, found);
    check("b2b_first_found", found, 1);
    check("b2b_first_res", bus.rsp_result, 32'd20);
    drive_req(1'b1, 1'b0, 32'd6, 32'd7, 5'd8);
    @(negedge clock);
    clear_req();
    check("b2b_issue_pulse", bus.md_ctrl_MULT, 1);
    check("b2b_issue_valid", bus.rsp_valid, 0);
    check("b2b_hold_res", bus.rsp_result, 32'd20);
    check("b2b_hold_tag", bus.rsp_tag, 5'd6);
    check("b2b_opA", bus.md_operandA, 32'd6);
    wait_valid(10, found);
    check("b2b_second_found", found, 1);
    check("b2b_second_res", bus.rsp_result, 32'd42);
    check("b2b_second_tag", bus.rsp_tag, 5'd8);
    $display("back-to-back: second res=0x%08h tag=%0d", bus.rsp_result, bus.rsp_tag);

    // Flush in DONE: response still out, simultaneous request dropped
    stub_lat = 2;
    @(negedge clock);
    drive_req(1'b1, 1'b0, 32'd3, 32'd3, 5'd1);
    @(negedge clock);
    clear_req();
    wait_valid(10, found);
    check("fd_found", found, 1);
    check("fd_res", bus.rsp_result, 32'd9);
    drive_req(1'b1, 1'b0, 32'd5, 32'd5, 5'd2);
    bus.flush = 1'b1;
    @(negedge clock);
    clear_req();
    check("fd_no_pulse", bus.md_ctrl_MULT, 0);
    check("fd_not_busy", bus.busy, 0);
    check("fd_no_valid", bus.rsp_valid, 0);
    $display("flush-in-done: res=0x%08h busy=%0d", bus.rsp_result, bus.busy);

`ifdef MULTDIV_TIMEOUT_EN
    run_op(0, 1, 32'd1, 32'd1, 5'd10, 0, 0, 0, 50,
           n_valid, valid_cyc, mult_p, div_p, res, exc, rtag, stable, busy_post);
    $display("timeout: cycle=%0d exc=%0d res=0x%08h", valid_cyc, exc, res);
    check("to_nvalid", n_valid, 1);
    check("to_cycle", valid_cyc, 42);
    check("to_exc", exc, 1);
    check("to_res", res, 32'd0);
    check("to_tag", rtag, 5'd10);
`endif

    // Reset in the middle of WAIT
    stub_lat = 20;
    @(negedge clock);
    drive_req(1'b0, 1'b1, 32'd8, 32'd2, 5'd12);
    @(negedge clock);
    clear_req();
    repeat (3) @(negedge clock);
    check("mid_busy_before", bus.busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check_all_zero("midrst");
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (bus.rsp_valid) cnt++;
    end
    check("midrst_no_valid", cnt, 0);
    check("midrst_idle", bus.busy, 0);
    $display("mid-wait reset: late responses=%0d", cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
